// File: rtl/data_mem_resp_pkg.sv
// Shared types and constants for the data-memory responder and its timer block.
// Optional build macro: DATA_MEM_ERR_EN (adds the access-error status bit and err port).
`ifndef RegDataBus
`define RegDataBus 31:0
`endif

package data_mem_resp_pkg;

  typedef logic [`RegDataBus] reg_data_t;

  // Timer register word offsets, taken from addr[3:2].
  typedef enum logic [1:0] {
    OffCount  = 2'd0,
    OffCmp    = 2'd1,
    OffCtrl   = 2'd2,
    OffStatus = 2'd3
  } mmio_off_e;

  // Bit positions inside the CTRL and STATUS registers.
  localparam int unsigned CtrlEnBit          = 0;
  localparam int unsigned CtrlAutoReloadBit  = 1;
  localparam int unsigned CtrlIrqEnBit       = 2;
  localparam int unsigned StatusMatchBit     = 0;
  localparam int unsigned StatusAccessErrBit = 1;

  // CTRL packed in the same bit order as CtrlEnBit/CtrlAutoReloadBit/CtrlIrqEnBit.
  typedef struct packed {
    logic irq_en;
    logic auto_reload;
    logic en;
  } ctrl_t;

  localparam reg_data_t CountRst = 32'h0000_0000;
  localparam reg_data_t CmpRst   = 32'hFFFF_FFFF;

endpackage

// File: rtl/data_mem_resp_if.sv
// CPU data-memory port: MEM-stage request signals plus same-cycle read data.
interface data_mem_resp_if;
  import data_mem_resp_pkg::*;

  logic      ce;
  logic      wrn;
  reg_data_t addr;
  reg_data_t wrdata;
  reg_data_t redata;

  modport master (output ce, output wrn, output addr, output wrdata, input redata);
  modport slave  (input ce, input wrn, input addr, input wrdata, output redata);
endinterface

// File: rtl/data_mem_resp_mem_timer.sv
// Memory-mapped timer: COUNT/CMP/CTRL/STATUS registers, compare/reload logic and irq.
// Optional build macro: DATA_MEM_ERR_EN (sticky access_err in STATUS bit1).
module data_mem_resp_mem_timer
  import data_mem_resp_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      we_i,
  input  mmio_off_e off_i,
  input  reg_data_t wdata_i,
`ifdef DATA_MEM_ERR_EN
  input  logic      err_set_i,
  output logic      err_o,
`endif
  output reg_data_t rdata_o,
  output logic      irq_o
);

  reg_data_t count_q, count_d;
  reg_data_t cmp_q;
  ctrl_t     ctrl_q;
  logic      flag_q;
  logic      match;

  assign match = ctrl_q.en && (count_q == cmp_q);
  assign irq_o = flag_q && ctrl_q.irq_en;

  // Next COUNT: a CPU write wins over increment/reload.
  always_comb begin
    count_d = count_q;
    if (we_i && (off_i == OffCount)) begin
      count_d = wdata_i;
    end else if (ctrl_q.en) begin
      count_d = (match && ctrl_q.auto_reload) ? CountRst : count_q + 32'd1;
    end
  end

  // Register state; a match set beats a same-cycle W1C clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= CountRst;
      cmp_q   <= CmpRst;
      ctrl_q  <= '0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      if (we_i && (off_i == OffCmp)) cmp_q <= wdata_i;
      if (we_i && (off_i == OffCtrl)) ctrl_q <= ctrl_t'(wdata_i[2:0]);
      if (match) begin
        flag_q <= 1'b1;
      end else if (we_i && (off_i == OffStatus) && wdata_i[StatusMatchBit]) begin
        flag_q <= 1'b0;
      end
    end
  end

`ifdef DATA_MEM_ERR_EN
  logic aerr_q;
  assign err_o = aerr_q;

  // Sticky access error; set beats clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aerr_q <= 1'b0;
    end else if (err_set_i) begin
      aerr_q <= 1'b1;
    end else if (we_i && (off_i == OffStatus) && wdata_i[StatusAccessErrBit]) begin
      aerr_q <= 1'b0;
    end
  end
`endif

  // Register read mux.
  always_comb begin
    rdata_o = '0;
    unique case (off_i)
      OffCount:  rdata_o = count_q;
      OffCmp:    rdata_o = cmp_q;
      OffCtrl:   rdata_o = {29'b0, ctrl_q};
`ifdef DATA_MEM_ERR_EN
      OffStatus: rdata_o = {30'b0, aerr_q, flag_q};
`else
      OffStatus: rdata_o = {31'b0, flag_q};
`endif
      default:   rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: address decode, word RAM with async read, timer MMIO window.
// Optional build macro: DATA_MEM_ERR_EN (err port, misaligned accesses rejected).
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_resp_if.slave bus,
`ifdef DATA_MEM_ERR_EN
  output logic           err,
`endif
  output logic           irq
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  reg_data_t             mem [Depth];
  reg_data_t             tmr_rdata;
  logic [ADDR_WIDTH-1:0] ram_idx;
  mmio_off_e             off;
  logic                  mmio_sel;
  logic                  aligned;
  logic                  ram_we;
  logic                  tmr_we;

  assign mmio_sel = bus.ce && (bus.addr[31:4] == MMIO_BASE[31:4]);
  assign ram_idx  = bus.addr[ADDR_WIDTH+1:2];
  assign off      = mmio_off_e'(bus.addr[3:2]);

`ifdef DATA_MEM_ERR_EN
  logic bad_bits;
  logic err_set;

  assign aligned  = (bus.addr[1:0] == 2'b00);
  // Writes that touch bits CTRL/STATUS do not implement.
  assign bad_bits = mmio_sel && bus.wrn &&
                    (((off == OffCtrl) && (|bus.wrdata[31:3])) ||
                     ((off == OffStatus) && (|bus.wrdata[31:2])));
  assign err_set  = bus.ce && (!aligned || bad_bits);
`else
  assign aligned = 1'b1;
`endif

  assign ram_we = bus.ce && bus.wrn && !mmio_sel && aligned;
  assign tmr_we = mmio_sel && bus.wrn && aligned;

  // RAM write port; contents survive reset, but a write during reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && ram_we) mem[ram_idx] <= bus.wrdata;
  end

  // Same-cycle read data; writes and idle cycles return 0.
  always_comb begin
    bus.redata = '0;
    if (bus.ce && !bus.wrn && aligned) begin
      bus.redata = mmio_sel ? tmr_rdata : mem[ram_idx];
    end
  end

  data_mem_resp_mem_timer u_timer (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (tmr_we),
    .off_i     (off),
    .wdata_i   (bus.wrdata),
`ifdef DATA_MEM_ERR_EN
    .err_set_i (err_set),
    .err_o     (err),
`endif
    .rdata_o   (tmr_rdata),
    .irq_o     (irq)
  );

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: vector table plus timer/reset/error sequences.
module tb_data_mem_resp;

  localparam logic [31:0] ACount  = 32'hFFFF_0000;
  localparam logic [31:0] ACmp    = 32'hFFFF_0004;
  localparam logic [31:0] ACtrl   = 32'hFFFF_0008;
  localparam logic [31:0] AStatus = 32'hFFFF_000C;

  typedef struct {
    logic        ce;
    logic        wrn;
    logic [31:0] addr;
    logic [31:0] wrdata;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;
`ifdef DATA_MEM_ERR_EN
  logic err;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb_q [$];
  vec_t vecs [$];

  data_mem_resp_if bus ();

  data_mem_resp #(
    .ADDR_WIDTH (10),
    .MMIO_BASE  (32'hFFFF_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
`ifdef DATA_MEM_ERR_EN
    .err (err),
`endif
    .irq (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive after the rising edge, compare redata on the falling edge.
  task automatic cyc(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp, input string name);
    logic [31:0] want;
    @(posedge clk);
    #1;
    bus.ce = c;
    bus.wrn = w;
    bus.addr = a;
    bus.wrdata = d;
    sb_q.push_back(exp);
    @(negedge clk);
    want = sb_q.pop_front();
    check(name, bus.redata, want);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    cyc(1'b1, 1'b0, a, 32'h0, exp, name);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input string name);
    cyc(1'b1, 1'b1, a, d, 32'h0, name);
  endtask

  task automatic chk_irq(input logic exp, input string name);
    check(name, 32'(irq), 32'(exp));
  endtask

  initial begin
    bus.ce = 1'b0;
    bus.wrn = 1'b0;
    bus.addr = '0;
    bus.wrdata = '0;

    vecs.push_back('{1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF});
    vecs.push_back('{1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 32'h0000_1000, 32'h1234_5678, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'h1234_5678});
    vecs.push_back('{1'b1, 1'b1, 32'h0000_0004, 32'h1111_1111, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 32'h0000_0014, 32'hA5A5_0001, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0014, 32'h0, 32'hA5A5_0001});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF});
    vecs.push_back('{1'b1, 1'b0, ACount, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, ACmp, 32'h0, 32'hFFFF_FFFF});
    vecs.push_back('{1'b1, 1'b0, ACtrl, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, AStatus, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 1'b1, ACmp, 32'h0000_0055, 32'h0});
    vecs.push_back('{1'b1, 1'b0, ACmp, 32'h0, 32'h0000_0055});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0004, 32'h0, 32'h1111_1111});
    vecs.push_back('{1'b1, 1'b0, 32'hFFFF_0010, 32'h0, 32'hDEAD_BEEF});
    vecs.push_back('{1'b1, 1'b1, 32'hFFFE_FFFC, 32'h7777_0003, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0FFC, 32'h0, 32'h7777_0003});
    vecs.push_back('{1'b1, 1'b1, ACmp, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0010, 32'h0BAD_0BAD, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF});

    // Reset and idle state.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_redata", bus.redata, 32'h0);
    chk_irq(1'b0, "reset_irq");
`ifdef DATA_MEM_ERR_EN
    check("reset_err", 32'(err), 32'h0);
`endif

    foreach (vecs[i]) begin
      cyc(vecs[i].ce, vecs[i].wrn, vecs[i].addr, vecs[i].wrdata, vecs[i].exp,
          $sformatf("vec%0d", i));
    end

    // One-shot match with irq enabled.
    wr(ACmp, 32'd5, "os_cmp");
    wr(ACtrl, 32'b101, "os_ctrl");
    for (int i = 0; i < 6; i++) begin
      rd(ACount, 32'(i), $sformatf("os_count%0d", i));
      chk_irq(1'b0, "os_irq_pre");
    end
    rd(ACount, 32'd6, "os_count6");
    chk_irq(1'b1, "os_irq_set");
    rd(AStatus, 32'd1, "os_status");
    wr(AStatus, 32'd1, "os_w1c");
    chk_irq(1'b1, "os_irq_hold");
    rd(AStatus, 32'd0, "os_status_clr");
    chk_irq(1'b0, "os_irq_clr");
    wr(ACtrl, 32'd0, "os_stop");

    // Auto-reload, W1C racing a match, COUNT write while running.
    wr(ACount, 32'd0, "ar_count");
    wr(ACmp, 32'd3, "ar_cmp");
    wr(ACtrl, 32'b011, "ar_ctrl");
    for (int k = 0; k < 11; k++) begin
      rd(ACount, 32'(k % 4), $sformatf("ar_seq%0d", k));
      chk_irq(1'b0, "ar_irq_gated");
    end
    wr(AStatus, 32'd1, "ar_w1c_on_match");
    rd(AStatus, 32'd1, "ar_flag_kept");
    wr(AStatus, 32'd1, "ar_w1c_off_match");
    rd(AStatus, 32'd0, "ar_flag_cleared");
    rd(AStatus, 32'd0, "ar_flag_match_cycle");
    rd(AStatus, 32'd1, "ar_flag_reset");
    wr(ACount, 32'h100, "ar_count_wr");
    rd(ACount, 32'h100, "ar_count_100");
    rd(ACount, 32'h101, "ar_count_101");
    wr(ACtrl, 32'd0, "ar_stop");
    rd(ACount, 32'h103, "ar_hold0");
    rd(ACount, 32'h103, "ar_hold1");
    wr(AStatus, 32'd1, "ar_clear");

    // 32-bit wrap.
    wr(ACmp, 32'd5, "wrap_cmp");
    wr(ACount, 32'hFFFF_FFFE, "wrap_count");
    wr(ACtrl, 32'd1, "wrap_ctrl");
    rd(ACount, 32'hFFFF_FFFE, "wrap0");
    rd(ACount, 32'hFFFF_FFFF, "wrap1");
    rd(ACount, 32'h0, "wrap2");
    rd(ACount, 32'h1, "wrap3");
    wr(ACtrl, 32'd0, "wrap_stop");

    // Reset in the middle of a run, with a RAM write on the reset edge.
    wr(ACmp, 32'd2, "rr_cmp");
    wr(ACount, 32'd0, "rr_count");
    wr(ACtrl, 32'b101, "rr_ctrl");
    for (int i = 0; i < 4; i++) rd(ACount, 32'(i), $sformatf("rr_count%0d", i));
    chk_irq(1'b1, "rr_irq_before");
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.ce = 1'b1;
    bus.wrn = 1'b1;
    bus.addr = 32'h0000_0010;
    bus.wrdata = 32'hBAD0_BAD0;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.ce = 1'b0;
    @(negedge clk);
    chk_irq(1'b0, "rr_irq_after");
    rd(32'h0000_0010, 32'hDEAD_BEEF, "rr_ram_kept");
    rd(ACtrl, 32'h0, "rr_ctrl_rst");
    rd(ACmp, 32'hFFFF_FFFF, "rr_cmp_rst");
    rd(ACount, 32'h0, "rr_count_rst");
    rd(ACount, 32'h0, "rr_count_idle");
    rd(AStatus, 32'h0, "rr_status_rst");

`ifdef DATA_MEM_ERR_EN
    check("err_idle", 32'(err), 32'h0);
    rd(32'h0000_0012, 32'h0, "err_misaligned_rd");
    rd(AStatus, 32'd2, "err_status");
    check("err_set", 32'(err), 32'h1);
    wr(32'h0000_0011, 32'h0, "err_misaligned_wr");
    rd(32'h0000_0010, 32'hDEAD_BEEF, "err_wr_dropped");
    check("err_sticky", 32'(err), 32'h1);
    wr(AStatus, 32'd2, "err_w1c");
    rd(AStatus, 32'd0, "err_status_clr");
    check("err_clr", 32'(err), 32'h0);
    wr(ACtrl, 32'h8, "err_ctrl_bits");
    rd(ACtrl, 32'h0, "err_ctrl_val");
    check("err_ctrl_set", 32'(err), 32'h1);
    wr(AStatus, 32'd2, "err_w1c2");
    rd(AStatus, 32'd0, "err_status_clr2");
`else
    rd(32'h0000_0012, 32'hDEAD_BEEF, "mis_rd");
    wr(32'h0000_0015, 32'hCAFE_F00D, "mis_wr");
    rd(32'h0000_0014, 32'hCAFE_F00D, "mis_wr_word");
`endif

    @(posedge clk);
    #1 bus.ce = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
